// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, captures each word the instruction
// memory returns into a small circular queue and hands the head to decode.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pcplus8,
    output logic [31:0] fetch_count
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [PW-1:0] LAST_IDX = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_count_q, fetch_count_d;
    logic          dec_valid_q, dec_valid_d;
    logic [31:0]   dec_instr_q, dec_instr_d;
    logic [31:0]   dec_pc_q, dec_pc_d;
    logic [31:0]   dec_pcplus8_q, dec_pcplus8_d;

    logic [31:0]   instr_mem_q [QDEPTH];
    logic [31:0]   pc_mem_q    [QDEPTH];

    logic          pop;
    logic          push;
    logic          head_bypass;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;

    // Handshake decode; a redirect suppresses the fetch but not the pop.
    always_comb begin
        pop  = dec_valid_q & dec_ready;
        push = ~redirect_valid & ((count_q < FULL_CNT) | pop);
    end

    // Pointer, count and PC next-state.
    always_comb begin
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d      = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
                pc_d          = pc_q + 32'd4;
                fetch_count_d = fetch_count_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next head entry; forward the word being written when it becomes the head.
    always_comb begin
        head_bypass   = push & (wr_ptr_q == rd_ptr_d);
        head_instr    = head_bypass ? imem_rd : instr_mem_q[rd_ptr_d];
        head_pc       = head_bypass ? pc_q    : pc_mem_q[rd_ptr_d];
        dec_valid_d   = (count_d != '0);
        dec_instr_d   = '0;
        dec_pc_d      = '0;
        dec_pcplus8_d = '0;
        if (dec_valid_d) begin
            dec_instr_d   = head_instr;
            dec_pc_d      = head_pc;
            dec_pcplus8_d = head_pc + 32'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC_ALIGNED;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
            dec_valid_q   <= 1'b0;
            dec_instr_q   <= '0;
            dec_pc_q      <= '0;
            dec_pcplus8_q <= '0;
        end else begin
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_d;
            dec_valid_q   <= dec_valid_d;
            dec_instr_q   <= dec_instr_d;
            dec_pc_q      <= dec_pc_d;
            dec_pcplus8_q <= dec_pcplus8_d;
        end
    end

    // Queue storage needs no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[wr_ptr_q] <= imem_rd;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign fetch_count = fetch_count_q;
    assign dec_valid   = dec_valid_q;
    assign dec_instr   = dec_instr_q;
    assign dec_pc      = dec_pc_q;
    assign dec_pcplus8 = dec_pcplus8_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned QD  = 3;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus8;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pcplus8    (dec_pcplus8),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_rd = imem_addr ^ KEY;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RPC;
    logic [31:0] m_fc = '0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_fc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        ent_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
        chk("dec_pc", dec_pc, h.pc);
        chk("dec_instr", dec_instr, h.instr);
        chk("dec_pcplus8", dec_pcplus8, (mq.size() != 0) ? h.pc + 32'd8 : 32'd0);
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_count", fetch_count, m_fc);
    endtask

    // Drive one cycle of inputs, advance the model by the spec rules, check after the edge.
    task automatic apply(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop;
        logic push;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        pop  = (mq.size() != 0) && rdy;
        push = !rv && ((mq.size() < QD) || pop);
        if (rst) begin
            mq.delete();
            m_pc = RPC & 32'hFFFF_FFFC;
            m_fc = '0;
        end else if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pc: m_pc, instr: m_pc ^ KEY});
                m_pc = m_pc + 32'd4;
                m_fc = m_fc + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        model_check();
    endtask

    initial begin
        vec_t vt[$];
        vt.push_back('{1, 0, 32'h0,         1, 0, 32'h0,         32'h0,         0});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'h0,         32'h4,         1});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'h4,         32'h8,         2});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'h8,         32'hC,         3});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h8,         32'h10,        4});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h8,         32'h14,        5});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h8,         32'h14,        5});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h8,         32'h14,        5});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h8,         32'h14,        5});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'hC,         32'h18,        6});
        vt.push_back('{0, 1, 32'h103,       1, 0, 32'h0,         32'h100,       6});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'h100,       32'h104,       7});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h100,       32'h108,       8});
        vt.push_back('{0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,         32'hFFFF_FFF8, 8});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 9});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,         10});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'h0,         32'h4,         11});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h0,         32'h8,         12});
        vt.push_back('{1, 1, 32'h200,       1, 0, 32'h0,         32'h0,         0});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h0,         32'h4,         1});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h0,         32'h8,         2});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h0,         32'hC,         3});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h0,         32'hC,         3});
        vt.push_back('{0, 0, 32'h0,         0, 1, 32'h0,         32'hC,         3});
        vt.push_back('{0, 0, 32'h0,         1, 1, 32'h4,         32'h10,        4});

        #2;
        apply(1, 0, 32'h0, 1);
        foreach (vt[i]) begin
            apply(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy);
            chk($sformatf("vec%0d valid", i), 32'(dec_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d pc", i), dec_pc, vt[i].e_pc);
            chk($sformatf("vec%0d pcplus8", i), dec_pcplus8,
                vt[i].e_valid ? vt[i].e_pc + 32'd8 : 32'd0);
            chk($sformatf("vec%0d addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d fetch_count", i), fetch_count, vt[i].e_fc);
        end

        // Full queue held off by decode, then redirect: one bubble, no stale words.
        apply(0, 1, 32'h0000_0103, 0);
        chk("redir_full bubble", 32'(dec_valid), 32'd0);
        chk("redir_full addr", imem_addr, 32'h0000_0100);
        apply(0, 0, 32'h0, 0);
        chk("redir_full valid", 32'(dec_valid), 32'd1);
        chk("redir_full pc", dec_pc, 32'h0000_0100);
        chk("redir_full instr", dec_instr, 32'h0000_0100 ^ KEY);

        // Reset together with redirect on a partly full queue.
        apply(0, 0, 32'h0, 0);
        apply(1, 1, 32'h0000_0400, 1);
        chk("rst_redir addr", imem_addr, RPC);
        chk("rst_redir valid", 32'(dec_valid), 32'd0);
        chk("rst_redir fc", fetch_count, 32'd0);

        for (int c = 0; c < 10000; c++) begin
            logic rst;
            logic rv;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 499) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                               : $urandom;
            apply(rst, rv, rpc, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage of the ARM single-cycle processor, directly upstream of the instruction memory. It owns the program counter and drives the word address into the instruction memory, which returns `imem_rd` combinationally in the same cycle. It captures each returned word with its PC into a small FIFO and presents the queue head to decode through a valid/ready handshake. Branch redirects flush the queue and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] are forced to 0.
- `QDEPTH`, default 2: queue entries; legal values are 2..8.
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out 32: byte address to the instruction memory; equals the `pc` register.
- `imem_rd` in 32: instruction word for `imem_addr`, valid in the same cycle.
- `redirect_valid` in 1: branch taken or PC write from execute.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored.
- `dec_ready` in 1: decode accepts the head entry this cycle.
- `dec_valid` out 1: the queue is non-empty.
- `dec_instr` out 32: head instruction.
- `dec_pc` out 32: address of the head instruction.
- `dec_pcplus8` out 32: `dec_pc`+8 mod 2^32 (the ARM R15 read value).
- `fetch_count` out 32: number of words pushed since reset; wraps at 2^32.

## Operation
- State:
  - `pc`[31:0], with bits [1:0] always 0.
  - Circular queue of `QDEPTH` entries holding {instr, pc}.
  - Read pointer, write pointer and `count`.
  - `fetch_count`.
- pop = `dec_valid` & `dec_ready`.
- push = !`redirect_valid` & ((`count` < `QDEPTH`) | pop).
- On push:
  - The queue stores {`imem_rd`, `pc`}.
  - `pc` <= `pc`+4 mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - `fetch_count` increments.
- If push is false, `pc` holds, except on redirect.
- Redirect (`redirect_valid`=1):
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - `count`, read pointer and write pointer are cleared to 0; every entry is discarded.
  - No push happens that cycle.
  - A pop in the same cycle still counts as a completed transfer for decode.
- Simultaneous pop and push:
  - With the queue full, both occur and `count` is unchanged, giving a throughput of 1 per cycle.
  - With the queue empty, only the push occurs, because `dec_valid`=0 means no pop.
- Outputs:
  - `dec_valid` = (`count` != 0).
  - `dec_instr`, `dec_pc` and `dec_pcplus8` come from the head entry.
  - All three are forced to 0 when `dec_valid`=0.
- Priority: `reset` > `redirect_valid` > push/pop.
- Pointers wrap modulo `QDEPTH`; the design must handle depths that are not a power of two.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `count`=0, `dec_valid`=0.
  - `dec_instr`=`dec_pc`=`dec_pcplus8`=0.
  - `fetch_count`=0.
- Reset asserted mid-operation clears all state at that edge and overrides any concurrent redirect or handshake.
- Fetch latency: a word addressed in cycle N is visible on `dec_*` in cycle N+1, provided it is the queue head.
- After reset deassertion, the first `dec_valid`=1 appears one cycle later with `dec_pc`=`RESET_PC`.
- Redirect penalty:
  - Redirect sampled at edge E.
  - The target is fetched in cycle E+1.
  - `dec_valid`=1 with `dec_pc`=target in cycle E+2.
  - Exactly one cycle with `dec_valid`=0 between.
- Sustained rate with `dec_ready`=1 continuously: one instruction per cycle, and the queue never exceeds 1 entry.
- `imem_addr` changes only on clock edges; there is no combinational path from any input to `imem_addr`.
- The `dec_*` outputs depend only on registered state; there is no combinational path from `dec_ready` to `dec_valid`.

## Test plan
- Reset release, with `RESET_PC`=0, `dec_ready`=1 and imem holding the pattern word = address ^ 32'hA5A5_0000:
  - `dec_pc` sequence is 0,4,8,...
  - `dec_pcplus8`=`dec_pc`+8 on every cycle.
  - `dec_valid` rises 1 cycle after reset.
- Backpressure (`dec_ready`=0 for 5 cycles, then 1):
  - `count` saturates at `QDEPTH` and `pc` holds at `RESET_PC`+4·`QDEPTH`.
  - No entry is lost or duplicated; `fetch_count` equals the number of distinct words delivered, plus `count`.
- Redirect to 32'h0000_0103 while the queue is full:
  - Next `dec_valid` shows `dec_pc`=32'h0000_0100 after exactly one empty cycle.
  - Stale entries never appear.
- Redirect to 32'hFFFF_FFF8 with `dec_ready`=1:
  - `dec_pc` reads FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - `dec_pcplus8` of FFFF_FFFC is 0000_0004.
- Reset asserted in the same cycle as `redirect_valid` with a partly full queue:
  - Next cycle `pc`=`RESET_PC`, `dec_valid`=0 and `fetch_count`=0.
- Random `dec_ready` and random redirects over 10k cycles against a reference model:
  - Delivered {pc, instr} pairs match exactly.
